// File: rtl/approx_max_pkg.sv
// Shared constants, index types and width helpers for approx_max_stream.
// Optional truncation build: define APPROX_MAX_TRUNC_EN.
package approx_max_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_LANES       = 4;
  localparam int DEF_BEAT_W      = 8;
  localparam int DEF_APPROX_LSBS = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  typedef logic [idx_w(DEF_LANES)-1:0] lane_idx_t;
  typedef logic [DEF_BEAT_W-1:0]       beat_idx_t;

endpackage

// File: rtl/approx_max_tree.sv
// Combinational unsigned max over LANES operands.
// Ties go to the lowest lane index.
module approx_max_tree
  import approx_max_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int LANES = DEF_LANES,
  localparam int LW    = idx_w(LANES)
) (
  input  logic [LANES*WIDTH-1:0] i_ops,
  output logic [WIDTH-1:0]       o_max,
  output logic [LW-1:0]          o_lane
);

  // Strict compare keeps the earlier lane on equality.
  always_comb begin
    o_max  = i_ops[WIDTH-1:0];
    o_lane = '0;
    for (int i = 1; i < LANES; i++) begin
      if (i_ops[i*WIDTH +: WIDTH] > o_max) begin
        o_max  = i_ops[i*WIDTH +: WIDTH];
        o_lane = LW'(i);
      end
    end
  end

endmodule

// File: rtl/approx_max_stream.sv
// Streaming packet max: beat max (stage 1), running max (stage 2).
// Define APPROX_MAX_TRUNC_EN to zero APPROX_LSBS low bits before compare.
module approx_max_stream
  import approx_max_pkg::*;
#(
  parameter  int WIDTH       = DEF_WIDTH,
  parameter  int LANES       = DEF_LANES,
  parameter  int BEAT_W      = DEF_BEAT_W,
  parameter  int APPROX_LSBS = DEF_APPROX_LSBS,
  localparam int LW          = idx_w(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_max,
  output logic [LW-1:0]          out_lane,
  output logic [BEAT_W-1:0]      out_beat
);

`ifdef APPROX_MAX_TRUNC_EN
  localparam int LSBS = APPROX_LSBS;
`else
  localparam int LSBS = APPROX_LSBS * 0;
`endif

  localparam logic [WIDTH-1:0] LMASK = {WIDTH{1'b1}} << LSBS;

  logic                   w_en;
  logic [LANES*WIDTH-1:0] w_ops;
  logic [WIDTH-1:0]       w_tmax;
  logic [LW-1:0]          w_tlane;

  logic                   r_s1_valid;
  logic                   r_s1_last;
  logic [WIDTH-1:0]       r_s1_max;
  logic [LW-1:0]          r_s1_lane;

  logic [WIDTH-1:0]       r_max;
  logic [LW-1:0]          r_lane;
  logic [BEAT_W-1:0]      r_beat;
  logic [BEAT_W-1:0]      r_cnt;
  logic                   r_out_valid;

  assign w_en     = !r_out_valid | out_ready;
  assign in_ready = w_en;
  assign w_ops    = in_data & {LANES{LMASK}};

  approx_max_tree #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_tree (
    .i_ops  (w_ops),
    .o_max  (w_tmax),
    .o_lane (w_tlane)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_max   <= '0;
      r_s1_lane  <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_last <= in_last;
        r_s1_max  <= w_tmax;
        r_s1_lane <= w_tlane;
      end
    end
  end

  // r_cnt is the packet index of the beat in stage 1; zero marks a packet start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max  <= '0;
      r_lane <= '0;
      r_beat <= '0;
      r_cnt  <= '0;
    end else if (w_en && r_s1_valid) begin
      if (r_cnt == '0 || r_s1_max > r_max) begin
        r_max  <= r_s1_max;
        r_lane <= r_s1_lane;
        r_beat <= r_cnt;
      end
      if (r_s1_last)
        r_cnt <= '0;
      else if (r_cnt != {BEAT_W{1'b1}})
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_out_valid <= 1'b0;
    else if (w_en)
      r_out_valid <= r_s1_valid & r_s1_last;
  end

  assign out_valid = r_out_valid;
  assign out_max   = r_max;
  assign out_lane  = r_lane;
  assign out_beat  = r_beat;

endmodule

// File: tb/tb_approx_max_stream.sv
// Scoreboard bench for approx_max_stream (default parameters).
// Expected packet results come from a per-packet reference model.
module tb_approx_max_stream;

`ifdef APPROX_MAX_TRUNC_EN
  localparam logic [7:0] MASK = 8'hFC;
`else
  localparam logic [7:0] MASK = 8'hFF;
`endif

  typedef struct {
    logic [7:0] mx;
    logic [1:0] ln;
    logic [7:0] bt;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_max;
  logic [1:0]  out_lane;
  logic [7:0]  out_beat;

  int   checks   = 0;
  int   failures = 0;
  int   bp_mode  = 0;
  res_t exp_q[$];
  res_t m_cur;
  int   m_cnt    = 0;

  approx_max_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_lane  (out_lane),
    .out_beat  (out_beat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Packet result: largest (truncated) operand, first beat, then lowest lane.
  task automatic model_beat(input logic [31:0] d, input bit last);
    int         bm;
    int         bl;
    logic [7:0] v;
    bm = -1;
    bl = 0;
    for (int i = 0; i < 4; i++) begin
      v = d[8*i +: 8] & MASK;
      if (int'(v) > bm) begin
        bm = int'(v);
        bl = i;
      end
    end
    if (m_cnt == 0 || bm > int'(m_cur.mx)) begin
      m_cur.mx = 8'(bm);
      m_cur.ln = 2'(bl);
      m_cur.bt = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
    end
    m_cnt++;
    if (last) begin
      exp_q.push_back(m_cur);
      m_cnt = 0;
    end
  endtask

  task automatic send(input logic [31:0] d, input bit last);
    bit acc;
    int n;
    acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (n = 0; n < 200; n++) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (acc) model_beat(d, last);
    else begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=stalled required=accept");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
    end
  endtask

  function automatic logic [31:0] rnd_beat();
    logic [31:0] d;
    bit          tie;
    tie = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < 4; i++)
      d[8*i +: 8] = tie ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
    return d;
  endfunction

  // Monitor: drives out_ready, pops and compares on each retire.
  initial begin : monitor
    res_t e;
    bit   hold;
    logic [7:0] hm;
    logic [1:0] hl;
    logic [7:0] hb;
    hold = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
      @(negedge clk);
      #1;
      if (out_valid && !out_ready) begin
        if (hold) begin
          checks++;
          if (out_max !== hm || out_lane !== hl || out_beat !== hb) begin
            failures++;
            $display("FAIL hold actual=%0h/%0d/%0d required=%0h/%0d/%0d",
                     out_max, out_lane, out_beat, hm, hl, hb);
          end
        end
        hm = out_max;
        hl = out_lane;
        hb = out_beat;
        hold = 1'b1;
      end else begin
        hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL result actual=%0h/%0d/%0d required=none",
                   out_max, out_lane, out_beat);
        end else begin
          e = exp_q.pop_front();
          if (out_max !== e.mx || out_lane !== e.ln || out_beat !== e.bt) begin
            failures++;
            $display("FAIL result actual=%0h/%0d/%0d required=%0h/%0d/%0d",
                     out_max, out_lane, out_beat, e.mx, e.ln, e.bt);
          end
        end
      end
    end
  end

  initial begin : stim
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_max", 32'(out_max), 0);
    chk("rst_out_lane", 32'(out_lane), 0);
    chk("rst_out_beat", 32'(out_beat), 0);
    @(negedge clk);
    rst_n = 1'b1;

    send({8'd1, 8'd9, 8'd9, 8'd3}, 1'b1);
    @(negedge clk);
    #2;
    chk("lat_cycle1", 32'(out_valid), 0);
    @(negedge clk);
    #2;
    chk("lat_cycle2", 32'(out_valid), 1);
    wait_drain();

    send({8'd2, 8'd1, 8'd5, 8'd0}, 1'b0);
    send({8'd200, 8'd0, 8'd0, 8'd3}, 1'b0);
    send({8'd0, 8'd200, 8'd0, 8'd0}, 1'b1);
    send({8'h00, 8'h03, 8'h0E, 8'h0D}, 1'b1);
    wait_drain();

    bp_mode = 2;
    repeat (2) @(negedge clk);
    fork
      begin : stall_drv
        for (int k = 0; k < 4; k++) send(rnd_beat(), 1'b1);
      end
      begin : stall_chk
        int n;
        n = 0;
        @(negedge clk);
        #2;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          #2;
          n++;
        end
        chk("stall_valid", 32'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #2;
          chk("stall_in_ready", 32'(in_ready), 0);
        end
        bp_mode = 0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          #2;
          chk("burst_valid", 32'(out_valid), 1);
        end
        @(negedge clk);
        #2;
        chk("burst_end", 32'(out_valid), 0);
      end
    join
    wait_drain();

    send({8'd9, 8'd8, 8'd7, 8'd6}, 1'b0);
    send({8'd90, 8'd80, 8'd70, 8'd60}, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    #2;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    send({8'd0, 8'd0, 8'd0, 8'd7}, 1'b1);
    wait_drain();

    for (int b = 0; b < 300; b++)
      send((b == 299) ? (32'd50 << 16) : 32'd0, b == 299);
    wait_drain();

    bp_mode = 1;
    for (int p = 0; p < 150; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 3)) @(negedge clk);
        send(rnd_beat(), b == len - 1);
      end
    end
    bp_mode = 0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_max_stream.md
APPROX_MAX_STREAM -- requirements
Module: approx_max_stream

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 8, operand bit width (2..32).
- REQ-002 The block SHALL have parameter LANES, default 4, operands per beat (power of two, 2..16).
- REQ-003 The block SHALL have parameter BEAT_W, default 8, width of the beat counter and out_beat.
- REQ-004 The block SHALL have parameter APPROX_LSBS, default 2, low bits zeroed when approximation is compiled in (0..WIDTH-1).
- REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-007 The block SHALL have port in_valid, input, 1, the input beat is valid.
- REQ-008 The block SHALL have port in_ready, output, 1, the block accepts a beat this cycle.
- REQ-009 The block SHALL have port in_data, input, LANES*WIDTH, operands; lane i occupies bits [i*WIDTH +: WIDTH].
- REQ-010 The block SHALL have port in_last, input, 1, the beat is the final beat of a packet.
- REQ-011 The block SHALL have port out_valid, output, 1, a packet result is presented.
- REQ-012 The block SHALL have port out_ready, input, 1, the consumer takes the result.
- REQ-013 The block SHALL have port out_max, output, WIDTH, maximum over the packet.
- REQ-014 The block SHALL have port out_lane, output, clog2(LANES), lane of the winning operand.
- REQ-015 The block SHALL have port out_beat, output, BEAT_W, beat index (0-based) of the winning operand.

Function
- REQ-016 A beat SHALL be accepted exactly when in_valid and in_ready are both 1 in the same cycle.
- REQ-017 Pipeline advance enable en SHALL be (!out_valid | out_ready); in_ready SHALL equal en.
- REQ-018 Stage 1 SHALL register the per-beat maximum, its lane, in_last and a valid bit; operands are unsigned.
- REQ-019 Intra-beat ties SHALL resolve to the lowest lane index.
- REQ-020 Stage 2 SHALL hold the running max, lane and beat; on the first beat of a packet it loads stage 1 unconditionally.
- REQ-021 Stage 2 SHALL replace the running max only when the new beat max is strictly greater, so earlier beats win ties.
- REQ-022 The beat counter SHALL increment per stage-1 beat, saturate at 2^BEAT_W-1, and clear after a last beat.
- REQ-023 out_valid SHALL rise on the edge on which stage 2 absorbs a last beat: two cycles after the last beat is accepted with no stall.
- REQ-024 The out_* fields SHALL hold stable while out_valid=1 and out_ready=0; all stages stall and in_ready=0.
- REQ-025 When out_valid=1 and out_ready=1, the result SHALL retire and a new beat SHALL be accepted in the same cycle (full throughput).
- REQ-026 A single-beat packet (in_last on the first beat) SHALL report out_beat=0.
- REQ-027 Invalid cycles (in_valid=0) SHALL insert bubbles without altering the running state.

Reset
- REQ-028 Asserting rst_n low SHALL, asynchronously, clear all valid bits, counters and outputs to 0; out_valid=0 and in_ready=1 after release.
- REQ-029 Reset mid-packet SHALL discard the partial packet; the next accepted beat starts a new packet.

Configuration
- REQ-030 With APPROX_MAX_TRUNC_EN defined, the low APPROX_LSBS bits of each operand SHALL be forced to 0 before comparison, and out_max SHALL carry the truncated value.
- REQ-031 Without APPROX_MAX_TRUNC_EN, comparison SHALL be exact, APPROX_LSBS SHALL be ignored, and timing and handshake SHALL be identical.

Structure
- REQ-032 The shared package approx_max_pkg SHALL hold clog2 helpers, lane/beat index typedefs and the default parameter constants.
- REQ-033 The comparison tree SHALL be sub-module approx_max_tree (LANES operands in, max and lane out, combinational), instantiated once in stage 1.

Verification
- REQ-034 Directed test: one beat {3,9,9,1} with last (LANES=4, WIDTH=8) -> out_max=9, out_lane=1, out_beat=0, out_valid exactly 2 cycles after accept.
- REQ-035 Directed test: a 3-beat packet whose maxima are 5, 200, 200 -> out_max=200, out_beat=1 (earlier tie wins).
- REQ-036 Directed test: hold out_ready=0 for 5 cycles during a pending result -> in_ready=0 and outputs stable, then one result per cycle when out_ready=1.
- REQ-037 Directed test: with APPROX_MAX_TRUNC_EN, APPROX_LSBS=2, beat {0x0D,0x0E,0x03,0x00} -> out_max=0x0C, out_lane=0; without the macro -> out_max=0x0E, out_lane=1.
- REQ-038 Directed test: pulse rst_n low after beat 2 of a 4-beat packet -> out_valid=0; next packet {7,0,0,0} with last -> out_max=7, out_beat=0.
- REQ-039 Directed test: a 300-beat packet with BEAT_W=8 and the max on beat 299 -> out_beat=255 (saturated).
